// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and limits for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned WAIT_MAX = 7;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational byte-lane steering for stores and load extension
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    input  logic        is_unsigned,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        wmask     = 4'b0000;
        wdata_rep = wdata;
        rdata     = 32'd0;
        byte_v    = rword[{addr_lo, 3'b000} +: 8];
        half_v    = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: begin
                wmask     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = is_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata     = is_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            end
            SZ_WORD: begin
                wmask = 4'b1111;
                rdata = rword;
            end
            default: begin
                wmask = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_resp_ctrl.sv
// rtl/dmem_resp_ctrl.sv - handshaked data-memory responder with programmable wait states
module dmem_resp_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned WAIT_LOAD = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0] rword;
    logic [31:0] ld_data;
    logic [31:0] wdata_rep;
    logic [3:0]  wmask;
    logic        bad;
    logic        access;
    logic        mem_we;

    assign word_idx = addr_q[ADDR_W+1:2];
    assign rword    = mem[word_idx];

    dmem_lane_align u_align (
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .wdata       (wdata_q),
        .rword       (rword),
        .is_unsigned (uns_q),
        .wmask       (wmask),
        .wdata_rep   (wdata_rep),
        .rdata       (ld_data)
    );

    always_comb begin
        bad = (addr_q >> (ADDR_W + 2)) != 32'd0;
        case (size_q)
            SZ_BYTE: ;
            SZ_HALF: if (addr_q[0]) bad = 1'b1;
            SZ_WORD: if (addr_q[1:0] != 2'b00) bad = 1'b1;
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    cnt_d   = 3'(WAIT_LOAD);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    access  = 1'b1;
                    err_d   = bad;
                    rdata_d = (bad || we_q) ? 32'd0 : ld_data;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state_q is forced to IDLE by rst, so a store still counting down never writes
    assign mem_we = access && we_q && !bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// tb/tb_dmem_resp_ctrl.sv - scoreboard bench for dmem_resp_ctrl at one and four wait states
module tb_dmem_resp_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rst4;

    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        req_valid4, req_ready4, req_we4, req_unsigned4;
    logic [31:0] req_addr4, req_wdata4;
    logic [1:0]  req_size4;
    logic        rsp_valid4, rsp_ready4, rsp_err4, busy4;
    logic [31:0] rsp_rdata4;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    dmem_resp_ctrl #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    dmem_resp_ctrl #(.ADDR_W(10), .WAIT_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we4),
        .req_addr(req_addr4), .req_wdata(req_wdata4), .req_size(req_size4),
        .req_unsigned(req_unsigned4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_rdata(rsp_rdata4),
        .rsp_err(rsp_err4), .busy(busy4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns once rsp_valid is seen.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   lat;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency", lat, 2);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err);
        issue(we, addr, wdata, size, uns, exp_rdata, exp_err);
        wait_idle();
    endtask

    task automatic start4(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_we4 = we; req_addr4 = addr; req_wdata4 = wdata; req_size4 = 2'd2; req_unsigned4 = 1'b0;
        req_valid4 = 1'b1;
        @(posedge clk);
        #1 req_valid4 = 1'b0;
    endtask

    task automatic run4(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata);
        int lat;
        start4(we, addr, wdata);
        lat = 0;
        while (!rsp_valid4 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency4", lat, 5);
        check("rsp_rdata4", rsp_rdata4, exp_rdata);
        check("rsp_err4", {31'd0, rsp_err4}, 32'd0);
        lat = 0;
        while (busy4 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("idle4_timeout", {31'd0, busy4}, 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; rst4 = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
        rsp_ready = 1'b1;
        req_valid4 = 1'b0; req_we4 = 1'b0; req_addr4 = '0; req_wdata4 = '0; req_size4 = '0; req_unsigned4 = 1'b0;
        rsp_ready4 = 1'b1;

        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; rst4 = 1'b0;
        @(posedge clk);
        #1 check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // size: 0 byte, 1 half, 2 word
        run(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 1'b0);
        run(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
        run(1'b1, 32'h20, 32'h0,        2'd2, 1'b0, 32'h0, 1'b0);
        run(1'b1, 32'h21, 32'h80,       2'd0, 1'b0, 32'h0, 1'b0);
        run(1'b1, 32'h22, 32'h7F,       2'd0, 1'b0, 32'h0, 1'b0);
        run(1'b0, 32'h21, 32'h0,        2'd0, 1'b0, 32'hFFFFFF80, 1'b0);
        run(1'b0, 32'h21, 32'h0,        2'd0, 1'b1, 32'h00000080, 1'b0);
        run(1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 32'h007F8000, 1'b0);
        run(1'b0, 32'h20, 32'h0,        2'd1, 1'b0, 32'hFFFF8000, 1'b0);
        run(1'b0, 32'h20, 32'h0,        2'd1, 1'b1, 32'h00008000, 1'b0);
        run(1'b0, 32'h22, 32'h0,        2'd1, 1'b0, 32'h0000007F, 1'b0);
        run(1'b1, 32'h12, 32'h5555A5A5, 2'd1, 1'b0, 32'h0, 1'b0);
        run(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 32'hA5A5BEEF, 1'b0);

        run(1'b1, 32'h04,     32'h12345678, 2'd2, 1'b0, 32'h0, 1'b0);
        run(1'b0, 32'h03,     32'h0,        2'd1, 1'b0, 32'h0, 1'b1);
        run(1'b1, 32'h06,     32'hFFFFFFFF, 2'd2, 1'b0, 32'h0, 1'b1);
        run(1'b0, 32'h1000,   32'h0,        2'd2, 1'b0, 32'h0, 1'b1);
        run(1'b1, 32'h1004,   32'hFFFFFFFF, 2'd2, 1'b0, 32'h0, 1'b1);
        run(1'b1, 32'h04,     32'hFFFFFFFF, 2'd3, 1'b0, 32'h0, 1'b1);
        run(1'b0, 32'h04,     32'h0,        2'd2, 1'b0, 32'h12345678, 1'b0);

        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hA5A5BEEF, 1'b0);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111; req_size = 2'd2; req_unsigned = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rdata", rsp_rdata, 32'hA5A5BEEF);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_busy", {31'd0, busy}, 32'd0);
        check("post_hs_ready", {31'd0, req_ready}, 32'd1);
        begin
            exp_t e;
            e.rdata = 32'h0;
            e.err   = 1'b0;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check("accept_after_hs", {31'd0, busy}, 32'd1);
        req_valid = 1'b0;
        wait_idle();
        run(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'h11111111, 1'b0);

        run4(1'b1, 32'h40, 32'hCAFEF00D, 32'h0);
        run4(1'b0, 32'h40, 32'h0, 32'hCAFEF00D);
        start4(1'b1, 32'h40, 32'h0BADBEEF);
        @(posedge clk);
        #1 check("wait4_busy", {31'd0, busy4}, 32'd1);
        #2 rst4 = 1'b1;
        #1;
        check("arst_busy4", {31'd0, busy4}, 32'd0);
        check("arst_ready4", {31'd0, req_ready4}, 32'd0);
        check("arst_valid4", {31'd0, rsp_valid4}, 32'd0);
        check("arst_rdata4", rsp_rdata4, 32'd0);
        @(posedge clk);
        #1 rst4 = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (rsp_valid4) seen++;
        end
        check("no_rsp_after_abort", seen, 0);
        run4(1'b0, 32'h40, 32'h0, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        #1 check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
